// File: rtl/tlfsm_pkg.sv
// Shared definitions for the tlfsm_gen traffic-light sequencer:
// state encodings (as seen on o_state) and lamp patterns {red,yellow,green}.
package tlfsm_pkg;

    typedef enum logic [3:0] {
        ST_EW_G  = 4'h0,
        ST_EW_Y  = 4'h1,
        ST_NS_Y  = 4'h2,
        ST_NS_G  = 4'h3,
        ST_AR2   = 4'h5,
        ST_AR1   = 4'h6,
        ST_FLASH = 4'h8,
        ST_START = 4'hF
    } state_t;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tlfsm_gen_timer.sv
// tl_phase_timer: loadable down-counter for phase durations.
// A load of duration D yields max(D,1)-1, so a phase always spans at least
// one cycle; the count then decrements to 0 and holds there.
module tl_phase_timer #(
    parameter int T_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [T_WIDTH-1:0] i_dur,
    output logic [T_WIDTH-1:0] o_cnt,
    output logic               o_zero
);

    localparam logic [T_WIDTH-1:0] ONE = T_WIDTH'(1);

    logic [T_WIDTH-1:0] r_cnt;

    // Load clamped (duration-1) on phase entry, otherwise count down to 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= (i_dur == '0) ? '0 : i_dur - ONE;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - ONE;
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tlfsm_gen.sv
// tlfsm_gen: two-road traffic-light sequencer with programmable phase
// durations, all-red clearance, side-road actuation and flashing mode.
// Optional pedestrian walk phase is compiled in with `define TLFSM_PED_EN.
module tlfsm_gen
    import tlfsm_pkg::*;
#(
    parameter int T_WIDTH    = 8,
    parameter int FLASH_HALF = 4,
    parameter int ACTUATED   = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [T_WIDTH-1:0] i_ns_time,
    input  logic [T_WIDTH-1:0] i_ew_time,
    input  logic [T_WIDTH-1:0] i_y_time,
    input  logic [T_WIDTH-1:0] i_ar_time,
    input  logic               i_ew_req,
    input  logic               i_flash,
    output logic [3:0]         o_state,
    output logic [2:0]         o_ns_lamp,
    output logic [2:0]         o_ew_lamp,
    output logic [T_WIDTH-1:0] o_remaining,
    output logic               o_phase_done
`ifdef TLFSM_PED_EN
    ,
    input  logic               i_ped_req,
    output logic               o_ped_walk
`endif
);

    localparam logic [T_WIDTH-1:0] ONE = T_WIDTH'(1);
    localparam int                 BW  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [BW-1:0]      BCNT_LAST = BW'(FLASH_HALF - 1);

    state_t             r_state, w_next;
    logic [T_WIDTH-1:0] w_dur, w_cnt;
    logic               w_zero, w_load, w_nzero, w_dem_ok, w_ped_dem;
    logic               r_dem, r_done, r_blink;
    logic [BW-1:0]      r_bcnt;

    // Any state change reloads the timer; FLASH selects 0 so it reads 0 there.
    assign w_load  = (w_next != r_state);
    assign w_nzero = w_load ? (w_dur <= ONE) : (w_cnt <= ONE);

    tl_phase_timer #(.T_WIDTH(T_WIDTH)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_dur   (w_dur),
        .o_cnt   (w_cnt),
        .o_zero  (w_zero)
    );

`ifdef TLFSM_PED_EN
    logic r_ped, r_walk;
    assign w_ped_dem  = r_ped | i_ped_req;
    assign o_ped_walk = r_walk;

    // Ped latch: set on request (set wins), consumed on AR2 -> NS_G;
    // walk holds for the whole NS_G phase that consumed it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ped  <= 1'b0;
            r_walk <= 1'b0;
        end else begin
            if (i_ped_req)
                r_ped <= 1'b1;
            else if (r_state == ST_AR2 && w_next == ST_NS_G)
                r_ped <= 1'b0;
            r_walk <= (w_next == ST_NS_G) &&
                      ((r_state == ST_AR2 && w_ped_dem) || (r_state == ST_NS_G && r_walk));
        end
    end
`else
    assign w_ped_dem = 1'b0;
`endif

    // Current request is included so a one-cycle pulse releases NS_G at once.
    assign w_dem_ok = (ACTUATED != 0) ? (r_dem | i_ew_req | w_ped_dem) : 1'b1;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= ST_START;
        else
            r_state <= w_next;
    end

    // Next-state: flash overrides everything, otherwise advance on timer 0.
    always_comb begin
        w_next = ST_START;
        if (i_flash) begin
            w_next = ST_FLASH;
        end else begin
            case (r_state)
                ST_START: w_next = w_zero ? ST_NS_G : ST_START;
                ST_NS_G:  w_next = (w_zero && w_dem_ok) ? ST_NS_Y : ST_NS_G;
                ST_NS_Y:  w_next = w_zero ? ST_AR1  : ST_NS_Y;
                ST_AR1:   w_next = w_zero ? ST_EW_G : ST_AR1;
                ST_EW_G:  w_next = w_zero ? ST_EW_Y : ST_EW_G;
                ST_EW_Y:  w_next = w_zero ? ST_AR2  : ST_EW_Y;
                ST_AR2:   w_next = w_zero ? ST_NS_G : ST_AR2;
                ST_FLASH: w_next = ST_START;
                default:  w_next = ST_START;
            endcase
        end
    end

    // Duration sampled for the phase being entered.
    always_comb begin
        w_dur = '0;
        case (w_next)
            ST_NS_G:                  w_dur = i_ns_time;
            ST_EW_G:                  w_dur = i_ew_time;
            ST_NS_Y, ST_EW_Y:         w_dur = i_y_time;
            ST_START, ST_AR1, ST_AR2: w_dur = i_ar_time;
            default:                  w_dur = '0;
        endcase
    end

    // EW demand latch: set on request (set wins), cleared on EW_G entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_dem <= 1'b0;
        else if (i_ew_req)
            r_dem <= 1'b1;
        else if (w_next == ST_EW_G && r_state != ST_EW_G)
            r_dem <= 1'b0;
    end

    // Phase-done is registered so it reads 0 out of reset; it predicts
    // "timer will be 0 in a timed state" for the coming cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_done <= 1'b0;
        else
            r_done <= (w_next != ST_FLASH) && w_nzero;
    end

    // Blink: starts at 1 on FLASH entry, toggles every FLASH_HALF cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_next != ST_FLASH) begin
            r_blink <= 1'b0;
            r_bcnt  <= '0;
        end else if (r_state != ST_FLASH) begin
            r_blink <= 1'b1;
            r_bcnt  <= '0;
        end else if (r_bcnt == BCNT_LAST) begin
            r_blink <= ~r_blink;
            r_bcnt  <= '0;
        end else begin
            r_bcnt  <= r_bcnt + BW'(1);
        end
    end

    // Outputs decoded from registers only, so lamps move with o_state.
    always_comb begin
        o_ns_lamp = LAMP_R;
        o_ew_lamp = LAMP_R;
        case (r_state)
            ST_NS_G:  o_ns_lamp = LAMP_G;
            ST_NS_Y:  o_ns_lamp = LAMP_Y;
            ST_EW_G:  o_ew_lamp = LAMP_G;
            ST_EW_Y:  o_ew_lamp = LAMP_Y;
            ST_FLASH: begin
                o_ns_lamp = r_blink ? LAMP_Y : LAMP_OFF;
                o_ew_lamp = r_blink ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign o_state      = r_state;
    assign o_remaining  = w_cnt;
    assign o_phase_done = r_done;

endmodule

// File: tb/tb_tlfsm_gen.sv
// Bench for tlfsm_gen: a fixed-time instance (ACTUATED=0) and an actuated
// instance (ACTUATED=1) share stimulus. Table-driven cycle vectors cover the
// fixed-time sequence; hand-written sequences cover actuation, flash, reset
// and (with TLFSM_PED_EN) the pedestrian walk.
module tb_tlfsm_gen;

    localparam logic [3:0] S_START = 4'hF, S_NSG = 4'h3, S_NSY = 4'h2, S_AR1 = 4'h6;
    localparam logic [3:0] S_EWG = 4'h0, S_EWY = 4'h1, S_AR2 = 4'h5, S_FL = 4'h8;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ns_t = 8'd5, ew_t = 8'd4, y_t = 8'd2, ar_t = 8'd1;
    logic       ew_req = 1'b0, flash = 1'b0;
    logic [3:0] f_state, a_state;
    logic [2:0] f_ns, f_ew, a_ns, a_ew;
    logic [7:0] f_rem, a_rem;
    logic       f_done, a_done;
`ifdef TLFSM_PED_EN
    logic       ped_req = 1'b0;
    logic       f_walk, a_walk;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlfsm_gen #(.T_WIDTH(8), .FLASH_HALF(4), .ACTUATED(0)) u_fix (
        .i_clk(clk), .i_rst_n(rst_n), .i_ns_time(ns_t), .i_ew_time(ew_t),
        .i_y_time(y_t), .i_ar_time(ar_t), .i_ew_req(ew_req), .i_flash(flash),
        .o_state(f_state), .o_ns_lamp(f_ns), .o_ew_lamp(f_ew), .o_remaining(f_rem),
`ifdef TLFSM_PED_EN
        .i_ped_req(ped_req), .o_ped_walk(f_walk),
`endif
        .o_phase_done(f_done));

    tlfsm_gen #(.T_WIDTH(8), .FLASH_HALF(4), .ACTUATED(1)) u_act (
        .i_clk(clk), .i_rst_n(rst_n), .i_ns_time(ns_t), .i_ew_time(ew_t),
        .i_y_time(y_t), .i_ar_time(ar_t), .i_ew_req(ew_req), .i_flash(flash),
        .o_state(a_state), .o_ns_lamp(a_ns), .o_ew_lamp(a_ew), .o_remaining(a_rem),
`ifdef TLFSM_PED_EN
        .i_ped_req(ped_req), .o_ped_walk(a_walk),
`endif
        .o_phase_done(a_done));

    typedef struct {
        logic       rst_n;
        logic [7:0] ns;
        logic [7:0] y;
        logic [3:0] st;
        logic [2:0] nsl;
        logic [2:0] ewl;
        logic [7:0] rem;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] ns, input logic [7:0] y,
                       input logic [3:0] st, input logic [2:0] nsl, input logic [2:0] ewl,
                       input logic [7:0] rem, input logic done);
        vec_t v;
        v.rst_n = r; v.ns = ns; v.y = y; v.st = st;
        v.nsl = nsl; v.ewl = ewl; v.rem = rem; v.done = done;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the chosen instance shows state st (and remaining rem if rem>=0).
    task automatic wait_for(input bit use_act, input logic [3:0] st, input int rem, input string nm);
        int  n = 0;
        bit  hit;
        hit = 1'b0;
        while (n < 200) begin
            if (use_act) hit = (a_state == st) && (rem < 0 || int'(a_rem) == rem);
            else         hit = (f_state == st) && (rem < 0 || int'(f_rem) == rem);
            if (hit) break;
            step();
            n++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s timeout waiting for state %0h rem %0d", nm, st, rem);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fixed-time sequence: ns=5 ew=4 y=2 ar=1; then ns->9 mid-NS_G, y->0.
        add(0, 5, 2, S_START, R, R, 0, 0);
        add(1, 5, 2, S_NSG, G, R, 4, 0);
        add(1, 5, 2, S_NSG, G, R, 3, 0);
        add(1, 5, 2, S_NSG, G, R, 2, 0);
        add(1, 5, 2, S_NSG, G, R, 1, 0);
        add(1, 5, 2, S_NSG, G, R, 0, 1);
        add(1, 5, 2, S_NSY, Y, R, 1, 0);
        add(1, 5, 2, S_NSY, Y, R, 0, 1);
        add(1, 5, 2, S_AR1, R, R, 0, 1);
        add(1, 5, 2, S_EWG, R, G, 3, 0);
        add(1, 5, 2, S_EWG, R, G, 2, 0);
        add(1, 5, 2, S_EWG, R, G, 1, 0);
        add(1, 5, 2, S_EWG, R, G, 0, 1);
        add(1, 5, 2, S_EWY, R, Y, 1, 0);
        add(1, 5, 2, S_EWY, R, Y, 0, 1);
        add(1, 5, 2, S_AR2, R, R, 0, 1);
        add(1, 5, 2, S_NSG, G, R, 4, 0);
        add(1, 9, 2, S_NSG, G, R, 3, 0);
        add(1, 9, 2, S_NSG, G, R, 2, 0);
        add(1, 9, 2, S_NSG, G, R, 1, 0);
        add(1, 9, 2, S_NSG, G, R, 0, 1);
        add(1, 9, 0, S_NSY, Y, R, 0, 1);
        add(1, 9, 0, S_AR1, R, R, 0, 1);
        add(1, 9, 0, S_EWG, R, G, 3, 0);
        add(1, 9, 0, S_EWG, R, G, 2, 0);
        add(1, 9, 0, S_EWG, R, G, 1, 0);
        add(1, 9, 0, S_EWG, R, G, 0, 1);
        add(1, 9, 0, S_EWY, R, Y, 0, 1);
        add(1, 9, 0, S_AR2, R, R, 0, 1);
        for (int r = 8; r >= 0; r--) add(1, 9, 0, S_NSG, G, R, 8'(r), r == 0);
        add(1, 9, 0, S_NSY, Y, R, 0, 1);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            ns_t  = tbl[i].ns;
            y_t   = tbl[i].y;
            step();
            chk($sformatf("v%0d state", i), f_state, tbl[i].st);
            chk($sformatf("v%0d ns_lamp", i), f_ns, tbl[i].nsl);
            chk($sformatf("v%0d ew_lamp", i), f_ew, tbl[i].ewl);
            chk($sformatf("v%0d remaining", i), f_rem, tbl[i].rem);
            chk($sformatf("v%0d phase_done", i), f_done, tbl[i].done);
        end

        // Actuated instance holds NS_G with no demand; a pulse releases it.
        y_t = 8'd2;
        for (int k = 0; k < 50; k++) begin
            step();
            chk($sformatf("hold%0d state", k), a_state, S_NSG);
            chk($sformatf("hold%0d remaining", k), a_rem, 0);
            chk($sformatf("hold%0d done", k), a_done, 1);
        end
        ew_req = 1'b1;
        step();
        ew_req = 1'b0;
        chk("act release state", a_state, S_NSY);
        chk("act release ns_lamp", a_ns, Y);
        chk("act release remaining", a_rem, 1);

        // Flash from mid-EW_G, blink 010/000 every 4 cycles, exit via START.
        wait_for(1'b0, S_EWG, 2, "flash sync");
        flash = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("flash%0d state", k), f_state, S_FL);
            chk($sformatf("flash%0d ns_lamp", k), f_ns, ((k / 4) % 2 == 0) ? Y : O);
            chk($sformatf("flash%0d ew_lamp", k), f_ew, ((k / 4) % 2 == 0) ? Y : O);
            chk($sformatf("flash%0d remaining", k), f_rem, 0);
            chk($sformatf("flash%0d done", k), f_done, 0);
        end
        ar_t  = 8'd3;
        flash = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("clear%0d state", k), f_state, S_START);
            chk($sformatf("clear%0d lamps", k), {f_ns, f_ew}, {R, R});
            chk($sformatf("clear%0d remaining", k), f_rem, 2 - k);
            chk($sformatf("clear%0d done", k), f_done, k == 2);
        end
        step();
        chk("post flash state", f_state, S_NSG);
        chk("post flash remaining", f_rem, 8);

        // Reset during EW_Y with demand latched: latch must be cleared.
        ew_req = 1'b1;
        step();
        ew_req = 1'b0;
        wait_for(1'b1, S_EWY, 1, "ewy sync");
        ew_req = 1'b1;
        step();
        ew_req = 1'b0;
        rst_n  = 1'b0;
        step();
        rst_n  = 1'b1;
        chk("rst act state", a_state, S_START);
        chk("rst act lamps", {a_ns, a_ew}, {R, R});
        chk("rst act remaining", a_rem, 0);
        chk("rst act done", a_done, 0);
        chk("rst fix state", f_state, S_START);
`ifdef TLFSM_PED_EN
        chk("rst walk", f_walk, 0);
`endif
        for (int k = 0; k < 15; k++) step();
        chk("latch cleared state", a_state, S_NSG);
        chk("latch cleared remaining", a_rem, 0);
        chk("latch cleared done", a_done, 1);

`ifdef TLFSM_PED_EN
        // Pedestrian request during EW_G grants walk for the next NS_G only.
        wait_for(1'b0, S_EWG, -1, "ped ewg sync");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        wait_for(1'b0, S_NSG, -1, "ped nsg sync");
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("walk%0d", k), f_walk, 1);
            step();
        end
        chk("walk end state", f_state, S_NSY);
        chk("walk end", f_walk, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlfsm_gen.md
Name: tlfsm_gen

Overview:
- Next-generation two-road traffic-light sequencer.
- Adds runtime-programmable phase durations, all-red clearance, side-road actuation (demand latching) and a flashing-yellow fault/night mode.
- Drives per-road lamp vectors plus an encoded state.
- Sits beside the existing timing blocks, fed by one system clock; durations come from a config register block.

Parameters:
- T_WIDTH, 8, width of all duration inputs and the internal phase timer.
- FLASH_HALF, 8'd4, cycles per half-period of the flash blink (>=1).
- ACTUATED, 1, 1 = NS green holds until EW demand is latched; 0 = fixed-time cycling.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_ns_time  input  T_WIDTH  NS green duration in cycles.
- i_ew_time  input  T_WIDTH  EW green duration in cycles.
- i_y_time  input  T_WIDTH  yellow duration in cycles.
- i_ar_time  input  T_WIDTH  all-red clearance duration in cycles.
- i_ew_req  input  1  side-road vehicle detect; level or single-cycle pulse.
- i_flash  input  1  force flashing mode.
- o_state  output  4  encoded current state.
- o_ns_lamp  output  3  {red,yellow,green} for NS.
- o_ew_lamp  output  3  {red,yellow,green} for EW.
- o_remaining  output  T_WIDTH  cycles left in current timed phase, counting down to 0.
- o_phase_done  output  1  one-cycle pulse on the last cycle of every timed phase.

Behaviour:
- Clock and reset: single clock i_clk; synchronous active-low reset i_rst_n.
- Reset values: state=START; both lamps=3'b100; o_remaining=0; o_phase_done=0; demand latch=0; blink=0.
- States: START, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, FLASH.
- Normal sequence: START -> NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G.
- Phase timing:
  - On entry to a timed phase, the timer loads (duration - 1), sampled from the matching input that cycle.
  - Later input changes do not affect the running phase.
  - A duration of 0 is treated as 1.
  - The phase lasts exactly max(duration,1) cycles.
  - START uses i_ar_time.
- o_remaining equals the timer value. o_phase_done=1 when the timer is 0 in a timed state.
- Transition happens on the clock edge after the o_phase_done cycle.
- Actuation (ACTUATED=1):
  - Demand latch sets on any cycle with i_ew_req=1.
  - It clears on EW_G entry; a request in the same cycle as EW_G entry is lost-free, i.e. set wins.
  - NS_G leaves only when timer==0 AND latch=1. Otherwise it holds with timer at 0, o_phase_done held high, and o_remaining=0.
- ACTUATED=0: the latch is ignored and NS_G is fixed-time.
- Lamps by state:
  - NS_G: NS=001, EW=100.
  - NS_Y: NS=010, EW=100.
  - EW_G: NS=100, EW=001.
  - EW_Y: NS=100, EW=010.
  - START/AR1/AR2: both 100.
  - FLASH: both {0,blink,0}.
- Lamp outputs are registered: they change in the same cycle o_state changes.
- Flash mode:
  - i_flash=1 in any state enters FLASH on the next edge and aborts the current phase.
  - Blink toggles every FLASH_HALF cycles, starting at 1 on entry.
  - o_remaining=0 and o_phase_done=0 in FLASH.
  - i_flash deasserted -> START (full all-red clearance), then the normal sequence.
- Reset mid-operation: returns to START on the edge where i_rst_n=0. The demand latch is cleared.
- Illegal encodings: go to START next cycle.
- o_state encodings: START=4'hF, NS_G=3, NS_Y=2, AR1=6, EW_G=0, EW_Y=1, AR2=5, FLASH=8.

Optional Feature:
- Macro: TLFSM_PED_EN.
- Defined: adds port i_ped_req (1 bit) and output o_ped_walk (1 bit).
  - The pedestrian request is latched like the EW demand.
  - On AR2 -> NS_G with the ped latch set, o_ped_walk=1 for the whole NS_G phase; the latch clears on that entry.
  - A pedestrian request also counts as demand for leaving NS_G when ACTUATED=1.
  - o_ped_walk=0 in all other states and after reset.
- Undefined: the ports are absent and behaviour is unchanged.

Decomposition:
- Package tlfsm_pkg:
  - State encoding constants.
  - Lamp constants LAMP_R/LAMP_Y/LAMP_G/LAMP_OFF.
- Sub-module tl_phase_timer:
  - Loadable T_WIDTH down-counter with load, zero-clamp of duration, and zero flag.
  - Synchronous active-low reset; holds at 0.

Test Plan:
- Reset then ns=5, ew=4, y=2, ar=1, ACTUATED=0, no req: START 1 cycle, NS_G 5, NS_Y 2, AR1 1, EW_G 4, EW_Y 2, AR2 1; period 15 cycles; o_phase_done pulses at each phase end.
- ACTUATED=1, no i_ew_req for 50 cycles: stays NS_G with o_remaining=0; one-cycle i_ew_req pulse -> NS_Y next edge.
- Change i_ns_time 5->9 mid-NS_G: current phase still 5 cycles; the next NS_G is 9 cycles. i_y_time=0 -> yellow lasts 1 cycle.
- i_flash asserted mid-EW_G (remaining=2): FLASH next edge, lamps 010/010 toggling every 4 cycles; deassert -> START, both lamps 100 for ar cycles.
- Assert i_rst_n=0 for one cycle during EW_Y: START on that edge, lamps 100/100, latch cleared.
- TLFSM_PED_EN: i_ped_req pulse during EW_G -> o_ped_walk=1 for all of the next NS_G, 0 in the following cycle.
